// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, functs, datapath select codes,
// state codes and the opcode-class decoder used at DECODE.
package mips_ctrl_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_LUI   = 6'h0f,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2b
    } opcode_e;

    typedef enum logic [5:0] {
        FN_NOP   = 6'h00,
        FN_BREAK = 6'h0d,
        FN_ADD   = 6'h20,
        FN_SUB   = 6'h22,
        FN_AND   = 6'h24,
        FN_XOR   = 6'h26
    } funct_e;

    // Instruction class captured at DECODE so later states never look at Op/Funct again
    typedef enum logic [3:0] {
        CLS_NOP, CLS_ADD, CLS_SUB, CLS_AND, CLS_XOR, CLS_BREAK,
        CLS_BEQ, CLS_BNE, CLS_LW, CLS_SW, CLS_LUI, CLS_J
    } op_class_e;

    localparam logic [2:0] ALU_PASS_A = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;
    localparam logic [2:0] ALU_AND    = 3'b011;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_LUI    = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [7:0] ST_RESET        = 8'd0;
    localparam logic [7:0] ST_FETCH        = 8'd1;
    localparam logic [7:0] ST_FETCH_WAIT   = 8'd2;
    localparam logic [7:0] ST_PC_INC       = 8'd3;
    localparam logic [7:0] ST_DECODE       = 8'd4;
    localparam logic [7:0] ST_R_EXEC       = 8'd5;
    localparam logic [7:0] ST_R_WB         = 8'd6;
    localparam logic [7:0] ST_BRANCH       = 8'd7;
    localparam logic [7:0] ST_MEM_ADDR     = 8'd8;
    localparam logic [7:0] ST_MEM_ACC      = 8'd9;
    localparam logic [7:0] ST_MEM_ACC_WAIT = 8'd10;
    localparam logic [7:0] ST_LW_WB        = 8'd11;
    localparam logic [7:0] ST_LUI_WB       = 8'd12;
    localparam logic [7:0] ST_JUMP         = 8'd13;
    localparam logic [7:0] ST_HALT         = 8'd14;
    localparam logic [7:0] ST_EXCEPT       = 8'd15;

    function automatic op_class_e decode_class(input logic [5:0] op, input logic [5:0] funct);
        op_class_e cls;
        cls = CLS_NOP;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:   cls = CLS_ADD;
                    FN_SUB:   cls = CLS_SUB;
                    FN_AND:   cls = CLS_AND;
                    FN_XOR:   cls = CLS_XOR;
                    FN_BREAK: cls = CLS_BREAK;
                    default:  cls = CLS_NOP;
                endcase
            end
            OP_BEQ:  cls = CLS_BEQ;
            OP_BNE:  cls = CLS_BNE;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_LUI:  cls = CLS_LUI;
            OP_J:    cls = CLS_J;
            default: cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mips_wait_counter.sv
// Memory wait-state counter shared by instruction fetch and data access.
module mips_wait_counter #(
    parameter int unsigned WAIT = 2
) (
    input  logic Clk,
    input  logic Reset_signal,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int unsigned CntW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset_signal || clear) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign done = (WAIT == 0) || (cnt_q == CntW'(WAIT - 1));

endmodule

// File: rtl/mips_mc_control_fsm.sv
// Multicycle MIPS control FSM: Moore decode of datapath controls with configurable memory
// wait states, BEQ/BNE PC update, BREAK halt and arithmetic-overflow exception.
module mips_mc_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned STATE_W  = 8
) (
    input  logic               Clk,
    input  logic               Reset_signal,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               ALU_zero,
    input  logic               ALU_overflow,
    output logic [STATE_W-1:0] StateOut,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PC_load,
    output logic               BranchNe,
    output logic               wr,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegReset,
    output logic [2:0]         ALU_sel,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               IorD,
    output logic               RegDst,
    output logic               A_load,
    output logic               B_load,
    output logic               MDR_load,
    output logic               ALUOut_load,
    output logic               IR_load,
    output logic               A_reset,
    output logic               B_reset,
    output logic               MDR_reset,
    output logic               ALUOut_reset,
    output logic               IR_reset,
    output logic               PC_reset,
    output logic               Halted,
    output logic               Exception
);

    localparam logic [STATE_W-1:0] S_RESET        = STATE_W'(ST_RESET);
    localparam logic [STATE_W-1:0] S_FETCH        = STATE_W'(ST_FETCH);
    localparam logic [STATE_W-1:0] S_FETCH_WAIT   = STATE_W'(ST_FETCH_WAIT);
    localparam logic [STATE_W-1:0] S_PC_INC       = STATE_W'(ST_PC_INC);
    localparam logic [STATE_W-1:0] S_DECODE       = STATE_W'(ST_DECODE);
    localparam logic [STATE_W-1:0] S_R_EXEC       = STATE_W'(ST_R_EXEC);
    localparam logic [STATE_W-1:0] S_R_WB         = STATE_W'(ST_R_WB);
    localparam logic [STATE_W-1:0] S_BRANCH       = STATE_W'(ST_BRANCH);
    localparam logic [STATE_W-1:0] S_MEM_ADDR     = STATE_W'(ST_MEM_ADDR);
    localparam logic [STATE_W-1:0] S_MEM_ACC      = STATE_W'(ST_MEM_ACC);
    localparam logic [STATE_W-1:0] S_MEM_ACC_WAIT = STATE_W'(ST_MEM_ACC_WAIT);
    localparam logic [STATE_W-1:0] S_LW_WB        = STATE_W'(ST_LW_WB);
    localparam logic [STATE_W-1:0] S_LUI_WB       = STATE_W'(ST_LUI_WB);
    localparam logic [STATE_W-1:0] S_JUMP         = STATE_W'(ST_JUMP);
    localparam logic [STATE_W-1:0] S_HALT         = STATE_W'(ST_HALT);
    localparam logic [STATE_W-1:0] S_EXCEPT       = STATE_W'(ST_EXCEPT);

    logic [STATE_W-1:0] state_q, state_d;
    op_class_e          cls_q, cls_d;
    logic               cnt_clear, cnt_inc, cnt_done;
    logic [STATE_W-1:0] mem_done_state;

    mips_wait_counter #(
        .WAIT (MEM_WAIT)
    ) u_wait_counter (
        .Clk          (Clk),
        .Reset_signal (Reset_signal),
        .clear        (cnt_clear),
        .inc          (cnt_inc),
        .done         (cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (Reset_signal) begin
            state_q  <= S_RESET;
            cls_q    <= CLS_NOP;
            StateOut <= S_RESET;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            StateOut <= state_q;
        end
    end

    assign mem_done_state = (cls_q == CLS_LW) ? S_LW_WB : S_FETCH;

    always_comb begin
        state_d   = S_FETCH;
        cls_d     = cls_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                cnt_clear = 1'b1;
                state_d   = (MEM_WAIT > 0) ? S_FETCH_WAIT : S_PC_INC;
            end
            S_FETCH_WAIT: begin
                cnt_inc = 1'b1;
                state_d = cnt_done ? S_PC_INC : S_FETCH_WAIT;
            end
            S_PC_INC: state_d = S_DECODE;
            S_DECODE: begin
                cls_d = decode_class(Op, Funct);
                case (cls_d)
                    CLS_ADD, CLS_SUB, CLS_AND, CLS_XOR: state_d = S_R_EXEC;
                    CLS_BREAK:                          state_d = S_HALT;
                    CLS_BEQ, CLS_BNE:                   state_d = S_BRANCH;
                    CLS_LW, CLS_SW:                     state_d = S_MEM_ADDR;
                    CLS_LUI:                            state_d = S_LUI_WB;
                    CLS_J:                              state_d = S_JUMP;
                    default:                            state_d = S_FETCH;
                endcase
            end
            S_R_EXEC: begin
                if ((cls_q == CLS_ADD || cls_q == CLS_SUB) && ALU_overflow) begin
                    state_d = S_EXCEPT;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_MEM_ADDR: state_d = S_MEM_ACC;
            S_MEM_ACC: begin
                cnt_clear = 1'b1;
                state_d   = (MEM_WAIT > 0) ? S_MEM_ACC_WAIT : mem_done_state;
            end
            S_MEM_ACC_WAIT: begin
                cnt_inc = 1'b1;
                state_d = cnt_done ? mem_done_state : S_MEM_ACC_WAIT;
            end
            S_R_WB, S_BRANCH, S_LW_WB, S_LUI_WB, S_JUMP: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_EXCEPT: state_d = S_EXCEPT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        BranchNe     = 1'b0;
        wr           = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegReset     = 1'b0;
        ALU_sel      = ALU_PASS_A;
        MemtoReg     = MTR_ALUOUT;
        PCSource     = PCS_ALU;
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        IorD         = 1'b0;
        RegDst       = 1'b0;
        A_load       = 1'b0;
        B_load       = 1'b0;
        MDR_load     = 1'b0;
        ALUOut_load  = 1'b0;
        IR_load      = 1'b0;
        A_reset      = 1'b0;
        B_reset      = 1'b0;
        MDR_reset    = 1'b0;
        ALUOut_reset = 1'b0;
        IR_reset     = 1'b0;
        PC_reset     = 1'b0;
        Halted       = 1'b0;
        Exception    = 1'b0;
        case (state_q)
            S_RESET: begin
                RegReset     = 1'b1;
                A_reset      = 1'b1;
                B_reset      = 1'b1;
                MDR_reset    = 1'b1;
                ALUOut_reset = 1'b1;
                IR_reset     = 1'b1;
                PC_reset     = 1'b1;
            end
            S_FETCH, S_FETCH_WAIT: begin
                IR_load  = 1'b1;
                IRWrite  = 1'b1;
                MDR_load = 1'b1;
            end
            S_PC_INC: begin
                ALUSrcB = SRCB_FOUR;
                ALU_sel = ALU_ADD;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                A_load      = 1'b1;
                B_load      = 1'b1;
                ALUOut_load = 1'b1;
                ALUSrcB     = SRCB_IMM_SH;
                ALU_sel     = ALU_ADD;
            end
            S_R_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUOut_load = 1'b1;
                case (cls_q)
                    CLS_ADD: ALU_sel = ALU_ADD;
                    CLS_SUB: ALU_sel = ALU_SUB;
                    CLS_AND: ALU_sel = ALU_AND;
                    CLS_XOR: ALU_sel = ALU_XOR;
                    default: ALU_sel = ALU_PASS_A;
                endcase
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_sel     = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCS_ALUOUT;
                BranchNe    = (cls_q == CLS_BNE);
            end
            S_MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_IMM;
                ALU_sel     = ALU_ADD;
                ALUOut_load = 1'b1;
            end
            S_MEM_ACC, S_MEM_ACC_WAIT: begin
                IorD     = 1'b1;
                wr       = (cls_q == CLS_SW);
                MDR_load = (cls_q == CLS_LW);
            end
            S_LW_WB: begin
                MemtoReg = MTR_MDR;
                RegWrite = 1'b1;
            end
            S_LUI_WB: begin
                MemtoReg = MTR_LUI;
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
            end
            S_HALT:   Halted    = 1'b1;
            S_EXCEPT: Exception = 1'b1;
            default: ;
        endcase
    end

    assign PC_load = PCWrite | (PCWriteCond & (BranchNe ? ~ALU_zero : ALU_zero));

endmodule
